// File: rtl/rr_burst_arbiter_if.sv
// Requester-side and downstream-side beat bus for rr_burst_arbiter.
// Latency: none (signal bundle only).
// Backpressure: out_ready from downstream is routed back to exactly one req_ready bit.
interface rr_burst_arbiter_if #(
   parameter int PORT = 4,
   parameter int DATA = 32
);
   localparam int IDX = $clog2(PORT);

   logic [PORT-1:0]      req_valid;
   logic [PORT-1:0]      req_last;
   logic [PORT*DATA-1:0] req_data;
   logic [PORT-1:0]      req_ready;
   logic                 out_valid;
   logic                 out_last;
   logic [DATA-1:0]      out_data;
   logic [IDX-1:0]       out_id;
   logic                 out_ready;

   // Requesters plus downstream consumer
   modport master (
      output req_valid, req_last, req_data,
      input  req_ready,
      input  out_valid, out_last, out_data, out_id,
      output out_ready
   );

   // The arbiter itself
   modport slave (
      input  req_valid, req_last, req_data,
      output req_ready,
      output out_valid, out_last, out_data, out_id,
      input  out_ready
   );
endinterface

// File: rtl/rr_burst_arbiter.sv
// N:1 round-robin burst arbiter with data mux; grant locks until the winner's last beat.
// Latency: 1 cycle request-to-out_valid, 1 idle bubble between bursts.
// Backpressure: out_ready passes straight to the granted req_ready; others see 0.
module rr_burst_arbiter #(
   parameter int PORT     = 4,
   parameter int DATA     = 32,
   parameter int MAX_BEAT = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              hold,
   rr_burst_arbiter_if.slave bus,
   output logic              busy,
   output logic              burst_err
);
   localparam int IDX = $clog2(PORT);
   localparam int CNT = $clog2(MAX_BEAT + 1);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [IDX-1:0] r_ptr;
   logic [IDX-1:0] r_gnt;
   logic [CNT-1:0] r_beat;

   logic           pick_vld;
   logic [IDX-1:0] pick_idx;
   logic [IDX:0]   sum;
   logic [IDX-1:0] cand;
   logic           grant_now;
   logic           gnt_vld;
   logic           gnt_last;
   logic           hs;
   logic           err_hit;
   logic           rel;
   logic [IDX-1:0] ptr_adv;

   // Granted port's request and the handshake / release conditions
   assign gnt_vld   = bus.req_valid[r_gnt];
   assign gnt_last  = bus.req_last[r_gnt];
   assign hs        = (state == LOCK) && gnt_vld && bus.out_ready;
   // A non-last beat that fills the counter to MAX_BEAT is an overrun
   assign err_hit   = hs && !gnt_last && (r_beat == CNT'(MAX_BEAT - 1));
   assign rel       = hs && (gnt_last || err_hit);
   assign grant_now = (state == IDLE) && !hold && pick_vld;
   // Pointer advance wraps at PORT, so indices >= PORT are never reached
   assign ptr_adv   = (r_gnt == IDX'(PORT - 1)) ? '0 : r_gnt + IDX'(1);

   // Round-robin search from r_ptr; scanning downward lets the nearest requester win
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      sum      = '0;
      cand     = '0;
      for (int k = PORT - 1; k >= 0; k--) begin
         sum = {1'b0, r_ptr} + (IDX + 1)'(k);
         if (sum >= (IDX + 1)'(PORT)) begin
            sum = sum - (IDX + 1)'(PORT);
         end
         cand = sum[IDX-1:0];
         if (bus.req_valid[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state: grab a winner in IDLE, release on last beat or overrun
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_now) state_nxt = LOCK;
         LOCK:    if (rel)       state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant, pointer and beat counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr  <= '0;
         r_gnt  <= '0;
         r_beat <= '0;
      end else begin
         if (grant_now) begin
            r_gnt  <= pick_idx;
            r_beat <= '0;
         end else if (hs && (r_beat != CNT'(MAX_BEAT))) begin
            r_beat <= r_beat + CNT'(1);
         end
         if (rel) begin
            r_ptr <= ptr_adv;
         end
      end
   end

   // FSM outputs: mux the granted port downstream and route ready back to it only
   always_comb begin
      bus.req_ready = '0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.out_data  = '0;
      bus.out_id    = '0;
      busy          = 1'b0;
      burst_err     = 1'b0;
      if (state == LOCK) begin
         bus.out_valid        = gnt_vld;
         bus.out_last         = gnt_vld && gnt_last;
         bus.out_data         = bus.req_data[int'(r_gnt) * DATA +: DATA];
         bus.out_id           = r_gnt;
         busy                 = 1'b1;
         bus.req_ready[r_gnt] = bus.out_ready;
         burst_err            = err_hit;
      end
   end
endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- N:1 round-robin arbiter for multi-beat bursts, with a valid/ready handshake and an integrated data mux.
- Sits in front of a shared single-port downstream resource (bus, FIFO write port, execution unit).
- Arbitrates one cycle after a request, then locks the grant until the winner's beat with last is accepted downstream.
- Detects over-length bursts.

Parameters:
- PORT, 4, number of requesters (any value >= 2; not restricted to powers of two).
- DATA, 32, payload width per beat.
- MAX_BEAT, 16, burst length limit used for the error check (>= 1).
- IDX, $clog2(PORT), width of the port index (derived constant; do not override).
- CNT, $clog2(MAX_BEAT+1), width of the beat counter (derived constant; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- hold  in  1  when high, inhibits new arbitration; a locked burst continues.
- req_valid  in  PORT  per-port beat valid.
- req_last  in  PORT  per-port last-beat marker, qualified by req_valid.
- req_data  in  PORT*DATA  per-port payload; port i occupies bits [i*DATA +: DATA].
- req_ready  out  PORT  per-port accept; at most one bit high.
- out_valid  out  1  downstream beat valid.
- out_last  out  1  downstream last marker.
- out_data  out  DATA  downstream payload.
- out_id  out  IDX  index of the granted port.
- out_ready  in  1  downstream accept.
- busy  out  1  high while in LOCK.
- burst_err  out  1  one-cycle pulse on a beat-limit violation.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, r_ptr=0, r_gnt=0, r_beat=0.
  - All outputs 0: req_ready, out_valid, out_last, out_data, out_id, busy, burst_err.
- FSM has two states, IDLE and LOCK.
- IDLE:
  - req_ready=0, out_valid=0, out_data=0.
  - If hold=0 and |req_valid: select the first i with req_valid[i]=1, searching i = r_ptr, r_ptr+1, ... modulo PORT.
  - Register the winner into r_gnt, clear r_beat, go to LOCK.
  - If hold=1 or no request, stay in IDLE with r_ptr unchanged.
  - Wrap-around is modulo PORT, not modulo 2^IDX. Indices >= PORT are never granted.
- LOCK:
  - out_valid = req_valid[r_gnt]; out_last = req_last[r_gnt] & out_valid; out_data = req_data slice r_gnt; out_id = r_gnt; busy = 1.
  - req_ready[r_gnt] = out_ready; all other ready bits are 0.
  - A handshake is out_valid & out_ready. On each handshake r_beat increments (saturating at MAX_BEAT).
  - Handshake with out_last=1: go to IDLE and set r_ptr = (r_gnt+1) mod PORT. When r_gnt=PORT-1, r_ptr becomes 0.
  - Handshake with out_last=0 that makes r_beat reach MAX_BEAT: pulse burst_err for one cycle, force release to IDLE and advance r_ptr as above. The remainder of that burst re-arbitrates as a new burst.
  - hold has no effect in LOCK.
  - Requester dropping valid mid-burst: the grant stays locked, out_valid follows it low, no timeout.
  - Valid or data changes on non-granted ports never reach the outputs.
- Latency:
  - 1 cycle from req_valid rising (while IDLE) to out_valid.
  - 1 bubble cycle (IDLE) between consecutive bursts.
  - Single-beat bursts therefore sustain at most 1 beat per 2 cycles.
- Fairness: a continuously requesting port waits at most PORT-1 bursts.
- Reset asserted mid-burst: immediate return to the reset values; the partial burst is discarded with no error pulse.
- Outputs are combinational from registered state plus the granted port's inputs. No combinational path exists from out_ready to out_valid.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, then 1, with no requests -> all outputs 0, busy=0, state stays IDLE.
- Single request: PORT=4, req_valid=4'b0100, 3-beat burst (last on beat 3), out_ready=1 -> out_valid rises 1 cycle later, out_id=2, req_ready=4'b0100, 3 beats pass in order, then IDLE and r_ptr=3.
- Rotation: all 4 ports continuously request 1-beat bursts -> grant order 0,1,2,3,0 with out_id changing every 2 cycles; port 3 is followed by port 0.
- Lock under contention: port 1 sends a 4-beat burst while port 0 asserts valid; out_ready toggles 1,0,1,1,0,1 -> port 0 never sees req_ready until the port-1 last handshake; out_data equals port-1 data in beat order.
- Hold and non-power-of-two: PORT=3, hold=1 with req_valid=3'b111 -> stays IDLE. Drop hold -> grants 0,1,2,0; out_id never equals 3.
- Overrun: MAX_BEAT=4, a port sends 6 beats without last -> burst_err pulses on the 4th handshake, busy falls, and the port re-arbitrates for beats 5-6. Separately, assert reset_n low mid-burst -> outputs clear asynchronously with no burst_err.
